// File: rtl/dcm_clk_gen.sv
// dcm_clk_gen: synthesizable stand-in for the vendor clock manager.
//
// Generates CLK_OUT1 from CLK_IN1 with a fractional-N phase accumulator so that
// f_out = f_in * NUM / (2 * DEN). Also provides a one-cycle strobe on each
// CLK_OUT1 rise and a sticky LOCKED flag after LOCK_EDGES rises.
//
// Ports:
//   CLK_IN1   in   reference clock (rising edge); the only clock in the block
//   RESET     in   synchronous, active-high reset
//   CLK_OUT1  out  generated clock, straight from a flop
//   RISE_STB  out  high for one CLK_IN1 cycle when CLK_OUT1 goes 0->1
//   LOCKED    out  high once LOCK_EDGES rises have occurred; cleared only by RESET

module dcm_clk_gen #(
    parameter int unsigned NUM        = 1,
    parameter int unsigned DEN        = 1,
    parameter int unsigned LOCK_EDGES = 4
) (
    input  logic CLK_IN1,
    input  logic RESET,
    output logic CLK_OUT1,
    output logic RISE_STB,
    output logic LOCKED
);

    // acc < DEN and NUM <= DEN, so acc + NUM < 2*DEN always fits without truncation.
    localparam int unsigned AccW = $clog2(2 * DEN) + 1;
    localparam int unsigned CntW = $clog2(LOCK_EDGES + 1);

    localparam logic [AccW-1:0] NumW  = AccW'(NUM);
    localparam logic [AccW-1:0] DenW  = AccW'(DEN);
    localparam logic [CntW-1:0] LockW = CntW'(LOCK_EDGES);

    if (NUM < 1 || NUM > DEN || DEN < 1) begin : g_bad_params
        $error("dcm_clk_gen: illegal parameters NUM=%0d DEN=%0d", NUM, DEN);
    end

    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] sum;
    logic            wrap;
    logic            rise;
    logic            clk_q, clk_d;
    logic            stb_q, stb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            locked_q, locked_d;

    always_comb begin
        sum   = acc_q + NumW;
        wrap  = (sum >= DenW);
        acc_d = wrap ? (sum - DenW) : sum;
        clk_d = clk_q ^ wrap;
        // A wrap while the output is low is a 0->1 transition.
        rise  = wrap & ~clk_q;
        stb_d = rise;

        cnt_d = cnt_q;
        if (rise && (cnt_q != LockW)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        locked_d = locked_q | (cnt_d == LockW);
    end

    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            acc_q    <= '0;
            clk_q    <= 1'b0;
            stb_q    <= 1'b0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            clk_q    <= clk_d;
            stb_q    <= stb_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign CLK_OUT1 = clk_q;
    assign RISE_STB = stb_q;
    assign LOCKED   = locked_q;

endmodule

// File: tb/tb_dcm_clk_gen.sv
// Directed bench for dcm_clk_gen: three instances (NUM/DEN = 1/1, 1/5, 2/5) share
// one clock and reset; expected waveforms are closed-form functions of the edge
// index after reset release.

module tb_dcm_clk_gen;

    logic clk_40m = 1'b0;
    logic reset   = 1'b1;

    logic a_clk, a_stb, a_lock;
    logic b_clk, b_stb, b_lock;
    logic c_clk, c_stb, c_lock;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_40m = ~clk_40m;

    dcm_clk_gen #(.NUM(1), .DEN(1), .LOCK_EDGES(4)) u_a (
        .CLK_IN1 (clk_40m),
        .RESET   (reset),
        .CLK_OUT1(a_clk),
        .RISE_STB(a_stb),
        .LOCKED  (a_lock)
    );

    dcm_clk_gen #(.NUM(1), .DEN(5), .LOCK_EDGES(2)) u_b (
        .CLK_IN1 (clk_40m),
        .RESET   (reset),
        .CLK_OUT1(b_clk),
        .RISE_STB(b_stb),
        .LOCKED  (b_lock)
    );

    dcm_clk_gen #(.NUM(2), .DEN(5), .LOCK_EDGES(2)) u_c (
        .CLK_IN1 (clk_40m),
        .RESET   (reset),
        .CLK_OUT1(c_clk),
        .RISE_STB(c_stb),
        .LOCKED  (c_lock)
    );

    task automatic tick();
        @(posedge clk_40m);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a_clk"},  a_clk,  1'b0);
        chk({tag, " a_stb"},  a_stb,  1'b0);
        chk({tag, " a_lock"}, a_lock, 1'b0);
        chk({tag, " b_clk"},  b_clk,  1'b0);
        chk({tag, " b_stb"},  b_stb,  1'b0);
        chk({tag, " b_lock"}, b_lock, 1'b0);
        chk({tag, " c_clk"},  c_clk,  1'b0);
        chk({tag, " c_stb"},  c_stb,  1'b0);
        chk({tag, " c_lock"}, c_lock, 1'b0);
    endtask

    // Run n edges after reset release, checking every output against the
    // hand-derived patterns; k is the edge number counted from release.
    task automatic run_edges(input string phase, input int n);
        int c_rises = 0;
        int b_high  = 0;
        for (int k = 1; k <= n; k++) begin
            logic ea_clk, eb_clk, ec_clk, eb_stb, ec_stb;
            string t;
            tick();
            t = $sformatf("%s e%0d", phase, k);
            // 1/1: toggles every edge, rises on odd edges, 4th rise at edge 7.
            ea_clk = (k % 2) == 1;
            chk({t, " a_clk"},  a_clk,  ea_clk);
            chk({t, " a_stb"},  a_stb,  ea_clk);
            chk({t, " a_lock"}, a_lock, k >= 7);
            // 1/5: toggles every 5 edges, rises at 5,15,25...; 2nd rise at 15.
            eb_clk = ((k / 5) % 2) == 1;
            eb_stb = ((k % 5) == 0) && eb_clk;
            chk({t, " b_clk"},  b_clk,  eb_clk);
            chk({t, " b_stb"},  b_stb,  eb_stb);
            chk({t, " b_lock"}, b_lock, k >= 15);
            // 2/5: toggles at 3,5,8,10...; high on k%5 in {3,4}; 2nd rise at 8.
            ec_clk = ((k % 5) == 3) || ((k % 5) == 4);
            ec_stb = (k % 5) == 3;
            chk({t, " c_clk"},  c_clk,  ec_clk);
            chk({t, " c_stb"},  c_stb,  ec_stb);
            chk({t, " c_lock"}, c_lock, k >= 8);
            if (c_stb === 1'b1) c_rises++;
            if (b_clk === 1'b1) b_high++;
        end
        if (n == 100) begin
            chk_int({phase, " c_rises_100"}, c_rises, 20);
            chk_int({phase, " b_high_100"},  b_high,  50);
        end
    endtask

    initial begin
        // Held reset: every output low for 20 edges.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all_zero($sformatf("hold r%0d", i));
        end
        reset = 1'b0;
        run_edges("run1", 100);

        // Edge 101: the 1/1 instance is high and locked before the reset pulse.
        tick();
        chk("pre a_clk",  a_clk,  1'b1);
        chk("pre a_lock", a_lock, 1'b1);
        chk("pre b_lock", b_lock, 1'b1);

        // One-cycle mid-run reset forces everything low on the next edge.
        reset = 1'b1;
        tick();
        chk_all_zero("midrst");
        reset = 1'b0;
        run_edges("run2", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
